// File: rtl/nibble_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_sequencer
// Purpose  : Performs a (4*NIBBLES)-bit add or subtract by time-sharing one
//            external 4-bit ripple-carry adder slice. It processes one
//            nibble per cycle, LSB first. The inter-nibble carry is held in a
//            register between cycles.
// Ports    :
//   clk        in   1   clock, rising-edge active
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   request operands present
//   in_ready   out  1   request can be taken (IDLE only)
//   op_a       in   W   operand A
//   op_b       in   W   operand B
//   sub        in   1   0: A+B, 1: A-B (two's complement)
//   add_a      out  4   A nibble to the shared adder
//   add_b      out  4   B (or ~B) nibble to the shared adder
//   add_cin    out  1   carry into the shared adder
//   add_sum    in   4   shared adder sum (combinational)
//   add_cout   in   1   shared adder carry out (combinational)
//   out_valid  out  1   result available
//   out_ready  in   1   consumer takes the result
//   result     out  W   sum or difference
//   carry      out  1   final carry; for subtract 1 means no borrow
//   overflow   out  1   signed overflow
// Revision : 1.0  initial release
// ============================================================================
module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 sub,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry,
    output logic                 overflow
);

    localparam int C_W     = 4 * NIBBLES;
    localparam int C_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NIBBLES - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_ONE  = C_IDX_W'(1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [C_W-1:0]     r_a;
    logic [C_W-1:0]     r_b;        // already inverted for subtract
    logic               r_c;        // carry into the current nibble
    logic [C_IDX_W-1:0] r_idx;
    logic [C_W-1:0]     r_result;
    logic               r_carry;
    logic               r_overflow;

    logic               w_run;
    logic               w_last;
    logic [C_IDX_W+1:0] w_base;     // bit offset of the current nibble
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;

    assign w_run  = (r_state == C_ST_RUN);
    assign w_last = (r_idx == C_LAST_IDX);
    assign w_base = {r_idx, 2'b00};

    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];

    // The shared adder is only driven while an operation is in flight so
    // that any other user of the slice sees a quiet bus otherwise. Because
    // the gate comes from the asynchronously reset state register, a reset
    // silences the bus without waiting for a clock edge.
    assign add_a   = w_run ? w_a_nib : 4'h0;
    assign add_b   = w_run ? w_b_nib : 4'h0;
    assign add_cin = w_run ? r_c     : 1'b0;

    assign in_ready  = (r_state == C_ST_IDLE);
    assign out_valid = (r_state == C_ST_DONE);

    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= C_ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= 1'b0;
            r_idx      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B once here and
                        // seed the carry chain with 1.
                        r_a      <= op_a;
                        r_b      <= sub ? ~op_b : op_b;
                        r_c      <= sub;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_state  <= C_ST_RUN;
                    end
                end

                C_ST_RUN: begin
                    r_result[w_base +: 4] <= add_sum;
                    r_c                   <= add_cout;
                    if (w_last) begin
                        // Index is parked at 0 so the nibble mux never
                        // points past the operand for non-power-of-two
                        // NIBBLES.
                        r_idx      <= '0;
                        r_carry    <= add_cout;
                        // Signed overflow: both addends share a sign bit
                        // (B taken after optional inversion) and the sum's
                        // sign bit differs from it.
                        r_overflow <= (r_a[C_W-1] == r_b[C_W-1]) &&
                                      (add_sum[3] != r_a[C_W-1]);
                        r_state    <= C_ST_DONE;
                    end else begin
                        r_idx <= r_idx + C_IDX_ONE;
                    end
                end

                C_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= C_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_add_sequencer
// Purpose  : Self-checking bench for nibble_add_sequencer. One instance uses
//            NIBBLES=4 and a second uses NIBBLES=1. Each instance drives its
//            own combinational 4-bit adder model. Expected values come from
//            whole-word arithmetic on the operands.
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_add_sequencer;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- NIBBLES = 4 instance ----------------
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          sub = 1'b0;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic [3:0]    add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          carry;
    logic          overflow;

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_add_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow)
    );

    // ---------------- NIBBLES = 1 instance ----------------
    logic          n1_in_valid = 1'b0;
    logic          n1_in_ready;
    logic [3:0]    n1_op_a = '0;
    logic [3:0]    n1_op_b = '0;
    logic          n1_sub = 1'b0;
    logic [3:0]    n1_add_a;
    logic [3:0]    n1_add_b;
    logic          n1_add_cin;
    logic [3:0]    n1_add_sum;
    logic          n1_add_cout;
    logic          n1_out_valid;
    logic          n1_out_ready = 1'b0;
    logic [3:0]    n1_result;
    logic          n1_carry;
    logic          n1_overflow;

    assign {n1_add_cout, n1_add_sum} = 5'(n1_add_a) + 5'(n1_add_b) + 5'(n1_add_cin);

    nibble_add_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(n1_in_valid), .in_ready(n1_in_ready),
        .op_a(n1_op_a), .op_b(n1_op_b), .sub(n1_sub),
        .add_a(n1_add_a), .add_b(n1_add_b), .add_cin(n1_add_cin),
        .add_sum(n1_add_sum), .add_cout(n1_add_cout),
        .out_valid(n1_out_valid), .out_ready(n1_out_ready),
        .result(n1_result), .carry(n1_carry), .overflow(n1_overflow)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_res;   // most recent expected result, for hold checks

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {overflow, carry, result[15:0]} for a w-bit op.
    function automatic logic [17:0] model(input int w, input longint a, input longint b, input bit s);
        longint m, h, sa, sb, r, res;
        bit c, v;
        m   = longint'(1) << w;
        h   = m / 2;
        sa  = (a >= h) ? a - m : a;
        sb  = (b >= h) ? b - m : b;
        res = s ? (a - b) : (a + b);
        res = ((res % m) + m) % m;
        c   = s ? (a >= b) : (a + b >= m);
        r   = s ? (sa - sb) : (sa + sb);
        v   = (r >= h) || (r < -h);
        return {v, c, 16'(res)};
    endfunction

    // Carry into nibble j equals the carry (or no-borrow) of the low 4*j bits.
    function automatic bit exp_cin(input longint a, input longint b, input bit s, input int j);
        longint m, la, lb;
        m  = longint'(1) << (4 * j);
        la = a % m;
        lb = b % m;
        return s ? (la >= lb) : (la + lb >= m);
    endfunction

    // Starts at a negedge with the block idle; ends at the negedge where
    // out_valid should be high. Optionally completes the handshake.
    task automatic run4(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input bit handshake, input int delay);
        logic [17:0]  e;
        logic [W-1:0] bb;
        e       = model(W, longint'(a), longint'(b), s);
        bb      = s ? ~b : b;
        exp_res = e[15:0];
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op_a = a; op_b = b; sub = s;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        for (int j = 0; j < 4; j++) begin
            check("run_out_valid", 64'(out_valid), 64'd0);
            check("run_in_ready", 64'(in_ready), 64'd0);
            check("run_add_a", 64'(add_a), 64'(a[4*j +: 4]));
            check("run_add_b", 64'(add_b), 64'(bb[4*j +: 4]));
            check("run_add_cin", 64'(add_cin), 64'(exp_cin(longint'(a), longint'(b), s, j)));
            @(negedge clk);
        end
        check("done_out_valid", 64'(out_valid), 64'd1);
        check("done_result", 64'(result), 64'(e[15:0]));
        check("done_carry", 64'(carry), 64'(e[16]));
        check("done_overflow", 64'(overflow), 64'(e[17]));
        check("done_add_idle", 64'({add_a, add_b, add_cin}), 64'd0);
        if (handshake) begin
            for (int d = 0; d < delay; d++) begin
                @(negedge clk);
                check("wait_out_valid", 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("post_hs_out_valid", 64'(out_valid), 64'd0);
            check("post_hs_in_ready", 64'(in_ready), 64'd1);
            check("post_hs_result_hold", 64'(result), 64'(e[15:0]));
        end
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, input bit s);
        logic [17:0] e;
        logic [3:0]  bb;
        e  = model(4, longint'(a), longint'(b), s);
        bb = s ? ~b : b;
        check("n1_in_ready", 64'(n1_in_ready), 64'd1);
        n1_in_valid = 1'b1; n1_op_a = a; n1_op_b = b; n1_sub = s;
        @(posedge clk);
        @(negedge clk);
        n1_in_valid = 1'b0;
        n1_op_a = 4'($urandom); n1_op_b = 4'($urandom);
        check("n1_run_out_valid", 64'(n1_out_valid), 64'd0);
        check("n1_run_add_a", 64'(n1_add_a), 64'(a));
        check("n1_run_add_b", 64'(n1_add_b), 64'(bb));
        check("n1_run_add_cin", 64'(n1_add_cin), 64'(s));
        @(negedge clk);
        check("n1_done_out_valid", 64'(n1_out_valid), 64'd1);
        check("n1_done_result", 64'(n1_result), 64'(e[3:0]));
        check("n1_done_carry", 64'(n1_carry), 64'(e[16]));
        check("n1_done_overflow", 64'(n1_overflow), 64'(e[17]));
        n1_out_ready = 1'b1;
        @(negedge clk);
        n1_out_ready = 1'b0;
        check("n1_post_hs_in_ready", 64'(n1_in_ready), 64'd1);
    endtask

    initial begin
        // ---- reset state ----
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({carry, overflow}), 64'd0);
        check("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- directed cases ----
        run4(16'h1234, 16'h0FF1, 1'b0, 1'b1, 0);
        run4(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0);
        run4(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1);
        run4(16'h0003, 16'h0005, 1'b1, 1'b1, 0);
        run4(16'h8000, 16'h0001, 1'b1, 1'b1, 2);

        // ---- backpressure in DONE with new requests pulsing ----
        run4(16'hABCD, 16'h1111, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
            @(negedge clk);
            check("bp_result_hold", 64'(result), 64'(exp_res));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_add_idle", 64'({add_a, add_b, add_cin}), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        run4(16'h0F0F, 16'h00F1, 1'b0, 1'b1, 0);

        // ---- asynchronous reset in RUN at idx=2 ----
        check("mr_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h5678; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mr_add_a_idx2", 64'(add_a), 64'h2);
        #1 rst = 1'b1;
        #1;
        check("mr_in_ready_async", 64'(in_ready), 64'd1);
        check("mr_add_async", 64'({add_a, add_b, add_cin}), 64'd0);
        check("mr_out_valid_async", 64'(out_valid), 64'd0);
        check("mr_result_async", 64'(result), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_out_valid_held", 64'(out_valid), 64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mr_no_late_valid", 64'(out_valid), 64'd0);
        end
        run4(16'h00FF, 16'h0001, 1'b0, 1'b1, 0);

        // ---- randomized operations ----
        for (int i = 0; i < 30; i++) begin
            run4(W'($urandom), W'($urandom), 1'($urandom), 1'b1, int'($urandom_range(0, 3)));
        end

        // ---- NIBBLES = 1 instance ----
        run1(4'h9, 4'h8, 1'b0);
        run1(4'h3, 4'h5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            run1(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle controller that time-shares one external 4-bit ripple-carry full-adder slice to perform `4*NIBBLES`-bit add/subtract. It runs one nibble per cycle, LSB first, and keeps the carry in a register between cycles. It sits between a requesting datapath (valid/ready handshake on both sides) and the shared 4-bit adder, whose operand and carry pins it drives directly.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operation; word width W = 4*NIBBLES; minimum 1.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request operands present.
- `in_ready`  out  1  block can accept a request (high only in IDLE).
- `op_a`  in  W  operand A.
- `op_b`  in  W  operand B.
- `sub`  in  1  0 = A+B, 1 = A−B (two's complement).
- `add_a`  out  4  nibble of A to the shared adder.
- `add_b`  out  4  nibble of B (or ~B) to the shared adder.
- `add_cin`  out  1  carry into the shared adder.
- `add_sum`  in  4  adder sum, combinational from `add_a`/`add_b`/`add_cin`.
- `add_cout`  in  1  adder carry out, combinational.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  W  sum or difference.
- `carry`  out  1  final carry out; for subtract, 1 = no borrow (A ≥ B unsigned).
- `overflow`  out  1  signed overflow.

## Operation
- States: IDLE, RUN, DONE. Internal regs: `a_reg`, `b_reg` (W bits), `c_reg`, `idx` (ceil(log2 NIBBLES) bits, min 1), plus `result`/`carry`/`overflow`.
- IDLE:
  - `in_ready`=1.
  - On an edge with `in_valid`: `a_reg`<=`op_a`; `b_reg`<=`sub` ? ~`op_b` : `op_b`; `c_reg`<=`sub`; `idx`<=0; `result`<=0; go to RUN.
- RUN:
  - `add_a`=`a_reg`[4*idx+:4]; `add_b`=`b_reg`[4*idx+:4]; `add_cin`=`c_reg`.
  - Each edge: `result`[4*idx+:4]<=`add_sum`; `c_reg`<=`add_cout`; `idx`<=`idx`+1.
  - When `idx`==NIBBLES−1 on that edge:
    - `carry`<=`add_cout`.
    - `overflow`<=(`a_reg`[W−1]==`b_reg`[W−1]) && (`add_sum`[3]!=`a_reg`[W−1]).
    - Go to DONE.
- DONE: `out_valid`=1. On an edge with `out_ready`: go to IDLE. `result`/`carry`/`overflow` hold until the next accept.
- `add_a`, `add_b` and `add_cin` are 0 in every state except RUN.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE. `op_a`/`op_b`/`sub` changes after the accept edge have no effect.
- No accept in DONE: a new request is taken only from IDLE, so back-to-back operations take NIBBLES+2 cycles minimum.
- Reset (any state, any time) forces asynchronously:
  - state IDLE; `in_ready`=1; `out_valid`=0.
  - `result`=0, `carry`=0, `overflow`=0; `a_reg`/`b_reg`/`c_reg`/`idx`=0.
  - `add_*`=0.
  - An in-flight operation is discarded and never produces `out_valid`.

## Timing
- `in_ready` and `out_valid` decode combinationally from state; all other outputs come from registers or are muxed from registers by `idx`.
- Accept on edge k: RUN spans the cycles after edges k … k+NIBBLES−1, and `out_valid` goes high after edge k+NIBBLES (NIBBLES+1 cycles from the accept edge to the cycle with `out_valid` asserted, counting the accept cycle).
- Result handoff on edge m (`out_valid`&&`out_ready`): `in_ready`=1 in the cycle after edge m; earliest next accept is edge m+1.
- The shared adder sees exactly NIBBLES consecutive cycles of valid drive per operation, with `add_cin` in RUN cycle j equal to the carry out of RUN cycle j−1 (`sub` for j=0).
- NIBBLES=1: RUN lasts one cycle, and IDLE→RUN→DONE takes 2 edges.

## Test plan
Bench: `NIBBLES`=4 unless stated; a combinational 4-bit adder model is connected to `add_*`.
- 0x1234 + 0x0FF1, `sub`=0 → `result`=0x2225, `carry`=0, `overflow`=0; `out_valid` rises exactly after the 4th edge following accept; `add_cin` sequence 0,0,1,1.
- 0xFFFF + 0x0001 → 0x0000, `carry`=1, `overflow`=0; `add_cin` sequence 0,1,1,1.
- 0x7FFF + 0x0001 → 0x8000, `carry`=0, `overflow`=1. Then 0x0003 − 0x0005 → 0xFFFE, `carry`=0, `overflow`=0, first `add_cin`=1 and `add_b`=0xA. Then 0x8000 − 0x0001 → 0x7FFF, `carry`=1, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while pulsing `in_valid` with new operands → `result` stable, `in_ready`=0, no second operation starts. Then raise `out_ready` for 1 cycle → IDLE, `in_ready`=1 next cycle, the next accept works normally.
- Assert `rst` mid-cycle during RUN at `idx`=2 → `in_ready`=1 and `add_*`=0 immediately without waiting for an edge, `out_valid` never asserts, `result`=0. Then release reset and issue 0x00FF + 0x0001 → 0x0100.
- `NIBBLES`=1 build: 0x9 + 0x8 → `result`=0x1, `carry`=1, `overflow`=1, `out_valid` after 1 RUN cycle.
